// File: rtl/fir_out_decim_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fir_out_decim_pkg
// Description : Shared constants, sample type and reference requantiser for
//               the FIR output decimation stage.
// Revision    : 1.0  initial release
// ============================================================================
package fir_out_decim_pkg;

  // FIR datapath geometry; the FIR sum width follows from these
  localparam int DEF_BIT_PREC   = 8;
  localparam int DEF_TAPS       = 9;
  localparam int DEF_IN_W       = 2 * DEF_BIT_PREC + DEF_TAPS - 1;

  // Output stage defaults
  localparam int DEF_OUT_W      = 16;
  localparam int DEF_SHIFT      = 8;
  localparam int DEF_DECIM      = 4;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef logic signed [DEF_OUT_W-1:0] out_sample_t;

  // Round half toward +inf, drop DEF_SHIFT LSBs, clamp to the output range.
  // The extra MSB on the sum keeps the rounding add from wrapping.
  function automatic out_sample_t sat_round(input logic signed [DEF_IN_W-1:0] x,
                                            output logic sat);
    logic signed [DEF_IN_W:0]            sum;
    logic signed [DEF_IN_W:0]            q;
    logic [DEF_IN_W-DEF_OUT_W+1:0]       hi;
    sum = {x[DEF_IN_W-1], x} + (DEF_IN_W+1)'(2 ** (DEF_SHIFT - 1));
    q   = sum >>> DEF_SHIFT;
    hi  = q[DEF_IN_W:DEF_OUT_W-1];
    sat = !((&hi) || !(|hi));
    if (!sat)
      return q[DEF_OUT_W-1:0];
    else if (q[DEF_IN_W])
      return {1'b1, {(DEF_OUT_W-1){1'b0}}};
    else
      return {1'b0, {(DEF_OUT_W-1){1'b1}}};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fir_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fir_sync_fifo
// Description : Single-clock show-ahead FIFO. Head is presented on pop_data
//               whenever not empty; reads zero while empty. A push into a
//               full FIFO is accepted only if a pop happens the same cycle.
// Revision    : 1.0  initial release
// ============================================================================
module fir_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_level == '0);
  assign full      = (r_level == LW'(DEPTH));
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  assign level     = r_level;
  assign pop_data  = empty ? '0 : r_mem[r_rd_ptr];

  // Storage write; data is never overwritten because full blocks the push
  always_ff @(posedge clk) begin
    if (w_do_push)
      r_mem[r_wr_ptr] <= push_data;
  end

  // Pointers wrap naturally at DEPTH (power of two); level tracks occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push)
        r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)
        r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/fir_out_decim.sv
`default_nettype none
// ============================================================================
// Module      : fir_out_decim
// Description : FIR output stage. Keeps one of every DECIM valid samples,
//               rounds/saturates to OUT_W bits, registers the result and
//               buffers it in a show-ahead FIFO drained over valid/ready.
//               Sticky flags report saturation and dropped samples.
// Revision    : 1.0  initial release
// ============================================================================
module fir_out_decim
  import fir_out_decim_pkg::*;
#(
  parameter int IN_W       = DEF_IN_W,
  parameter int OUT_W      = DEF_OUT_W,
  parameter int SHIFT      = DEF_SHIFT,
  parameter int DECIM      = DEF_DECIM,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clr,
  input  logic                           in_valid,
  input  logic [IN_W-1:0]                in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [OUT_W-1:0]               out_data,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
  output logic                           sat_flag,
  output logic                           ovf_flag
);

  localparam int               PH_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int               HI_W  = IN_W - OUT_W + 2;
  localparam logic [IN_W:0]    c_RND = (IN_W + 1)'(1) << (SHIFT - 1);
  localparam logic [OUT_W-1:0] c_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] c_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  logic                    w_clear;
  logic                    w_phase_zero;
  logic                    w_keep;
  logic signed [IN_W:0]    w_ext;
  logic signed [IN_W:0]    w_sum;
  logic signed [IN_W:0]    w_q;
  logic [HI_W-1:0]         w_hi;
  logic                    w_sat;
  logic [OUT_W-1:0]        w_req;
  logic                    r_s1_valid;
  logic [OUT_W-1:0]        r_s1_data;
  logic                    w_full;
  logic                    w_empty;
  logic                    r_sat_flag;
  logic                    r_ovf_flag;

  assign w_clear = rst || clr;
  assign w_keep  = in_valid && w_phase_zero;

  generate
    if (DECIM > 1) begin : g_phase
      logic [PH_W-1:0] r_phase;
      // Phase advances only on valid input so gaps never shift the keep slot
      always_ff @(posedge clk) begin
        if (w_clear)
          r_phase <= '0;
        else if (in_valid)
          r_phase <= (r_phase == PH_W'(DECIM - 1)) ? '0 : r_phase + PH_W'(1);
      end
      assign w_phase_zero = (r_phase == '0);
    end else begin : g_no_phase
      assign w_phase_zero = 1'b1;
    end
  endgenerate

  // Requantiser: round half toward +inf then clamp if the upper bits are not
  // all sign copies
  always_comb begin
    w_ext = {in_data[IN_W-1], in_data};
    w_sum = w_ext + c_RND;
    w_q   = w_sum >>> SHIFT;
    w_hi  = w_q[IN_W:OUT_W-1];
    w_sat = !((&w_hi) || !(|w_hi));
    if (!w_sat)
      w_req = w_q[OUT_W-1:0];
    else if (w_q[IN_W])
      w_req = c_MIN;
    else
      w_req = c_MAX;
  end

  // Stage 1 register reloads every cycle; its content is pushed on the same
  // edge that would overwrite it
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
    end else begin
      r_s1_valid <= w_keep;
      r_s1_data  <= w_req;
    end
  end

  // Sticky flags; a drop happens only when full and no same-cycle pop
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_sat_flag <= 1'b0;
      r_ovf_flag <= 1'b0;
    end else begin
      if (w_keep && w_sat)
        r_sat_flag <= 1'b1;
      if (r_s1_valid && w_full && !out_ready)
        r_ovf_flag <= 1'b1;
    end
  end

  fir_sync_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (w_clear),
    .push      (r_s1_valid),
    .push_data (r_s1_data),
    .pop       (out_ready),
    .pop_data  (out_data),
    .full      (w_full),
    .empty     (w_empty),
    .level     (fifo_level)
  );

  assign out_valid = !w_empty;
  assign sat_flag  = r_sat_flag;
  assign ovf_flag  = r_ovf_flag;

endmodule
`default_nettype wire
